// File: rtl/ap_tag_scanner_if.sv
// Stream/control bundle between the CAM tag scanner and its consumer.
// master = consumer side (drives start/tags/idx_ready), slave = scanner.
interface ap_tag_scanner_if #(
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned AW         = $clog2(CELL_QUANT + 1)
);
  logic                  start;
  logic [CELL_QUANT-1:0] tags;
  logic                  idx_valid;
  logic                  idx_ready;
  logic [AW-1:0]         idx;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         match_count;
  logic                  any_match;

  modport master (
    output start, tags, idx_ready,
    input  idx_valid, idx, busy, done, match_count, any_match
  );

  modport slave (
    input  start, tags, idx_ready,
    output idx_valid, idx, busy, done, match_count, any_match
  );
endinterface

// File: rtl/ap_tag_scanner.sv
// Snapshots the CAM tag vector on start and streams matching cell indices in ascending order.
// Optional AP_SCAN_ABORT_EN adds an abort input that ends a scan early.
module ap_tag_scanner #(
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned CHUNK      = 32
) (
  input logic              CLK100MHZ,
  input logic              rst,
`ifdef AP_SCAN_ABORT_EN
  input logic              abort,
`endif
  ap_tag_scanner_if.slave  bus
);
  // clogb2 of a power of two: bits needed to hold CELL_QUANT itself
  localparam int unsigned AW     = $clog2(CELL_QUANT + 1);
  localparam int unsigned NCHUNK = CELL_QUANT / CHUNK;
  localparam int unsigned PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                state_q, state_d;
  logic [CELL_QUANT-1:0] snap_q, snap_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         count_q, count_d;
  logic                  any_q, any_d;

  logic [CHUNK-1:0]      cur;
  logic [CW-1:0]         low_pos;
  logic [AW-1:0]         idx_raw;
  logic                  offer;
  logic                  accept;
  logic                  last_chunk;
  logic                  abort_req;

`ifdef AP_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Priority encode the lowest set bit of the current chunk
  always_comb begin
    cur     = snap_q[ptr_q*CHUNK +: CHUNK];
    low_pos = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (cur[i]) low_pos = CW'(i);
    end
    idx_raw = AW'(ptr_q) * AW'(CHUNK) + AW'(low_pos);
  end

  assign offer      = (state_q == StScan) && (cur != '0);
  assign accept     = offer && bus.idx_ready;
  assign last_chunk = (ptr_q == PW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    any_d   = any_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          snap_d  = bus.tags;
          ptr_d   = '0;
          count_d = '0;
          any_d   = |bus.tags;
          state_d = StScan;
        end
      end
      StScan: begin
        // An accept in the abort cycle still counts
        if (accept) begin
          snap_d[idx_raw[AW-2:0]] = 1'b0;
          count_d                 = count_q + 1'b1;
        end
        if (abort_req) begin
          state_d = StDone;
        end else if (!offer) begin
          if (last_chunk) state_d = StDone;
          else            ptr_d   = ptr_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      any_q   <= any_d;
    end
  end

  assign bus.idx_valid   = offer;
  assign bus.idx         = offer ? idx_raw : '0;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.match_count = count_q;
  assign bus.any_match   = any_q;
endmodule

// File: tb/tb_ap_tag_scanner.sv
// Self-checking bench for ap_tag_scanner (CELL_QUANT=64, CHUNK=16) against a queue-based model.
// Define AP_SCAN_ABORT_EN to also exercise the abort path.
module tb_ap_tag_scanner;
  localparam int unsigned CQ  = 64;
  localparam int unsigned CH  = 16;
  localparam int unsigned AW  = 7;
  localparam int unsigned NCH = CQ / CH;

  logic clk = 1'b0;
  logic rst;
`ifdef AP_SCAN_ABORT_EN
  logic abort;
`endif

  always #5 clk = ~clk;

  ap_tag_scanner_if #(.CELL_QUANT(CQ), .AW(AW)) bus ();

  ap_tag_scanner #(.CELL_QUANT(CQ), .CHUNK(CH)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
`ifdef AP_SCAN_ABORT_EN
    .abort     (abort),
`endif
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: matching indices are simply the set bit positions, ascending
  task automatic build_exp(input logic [63:0] t);
    exp_q.delete();
    for (int i = 0; i < 64; i++) if (t[i]) exp_q.push_back(i);
  endtask

  // mode 0: ready always 1, 1: ready toggles, 2: ready random
  task automatic run_scan(input logic [63:0] t, input int mode, input bit disturb,
                          input string name);
    int            cyc;
    int            pop;
    bit            stalled;
    bit            seen_done;
    logic [AW-1:0] stall_idx;
    stalled   = 1'b0;
    seen_done = 1'b0;
    stall_idx = '0;
    build_exp(t);
    pop = exp_q.size();
    bus.tags  = t;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.tags  = {$urandom, $urandom};
    cyc = 1;
    check({name, " busy_scan"}, bus.busy, 1);
    while (!seen_done && cyc < 1000) begin
      if (stalled) begin
        check({name, " stall_valid"}, bus.idx_valid, 1);
        check({name, " stall_idx"}, bus.idx, stall_idx);
      end
      if (disturb && cyc == 5) begin
        bus.start = 1'b1;
        bus.tags  = '0;
      end else begin
        bus.start = 1'b0;
      end
      case (mode)
        0:       bus.idx_ready = 1'b1;
        1:       bus.idx_ready = ((cyc % 2) == 1);
        default: bus.idx_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.done) begin
        seen_done = 1'b1;
        if (mode == 0) check({name, " done_cycle"}, cyc, pop + NCH + 1);
        check({name, " leftover"}, exp_q.size(), 0);
        check({name, " match_count"}, bus.match_count, pop);
        check({name, " any_match"}, bus.any_match, (t != 0));
        check({name, " busy_in_done"}, bus.busy, 1);
        stalled = 1'b0;
      end else if (bus.idx_valid) begin
        if (exp_q.size() == 0) begin
          check({name, " extra_valid"}, bus.idx_valid, 0);
        end else if (bus.idx_ready) begin
          check({name, " idx"}, bus.idx, exp_q.pop_front());
        end
        stalled   = !bus.idx_ready;
        stall_idx = bus.idx;
      end else begin
        check({name, " idx_zero"}, bus.idx, 0);
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen_done) check({name, " timeout"}, seen_done, 1);
    check({name, " done_pulse"}, bus.done, 0);
    check({name, " idle_busy"}, bus.busy, 0);
    check({name, " hold_count"}, bus.match_count, pop);
    bus.start     = 1'b0;
    bus.idx_ready = 1'b0;
  endtask

  logic [63:0] t4;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.tags      = '0;
    bus.idx_ready = 1'b0;
`ifdef AP_SCAN_ABORT_EN
    abort         = 1'b0;
`endif
    #1;
    check("rst busy", bus.busy, 0);
    check("rst idx_valid", bus.idx_valid, 0);
    check("rst idx", bus.idx, 0);
    check("rst done", bus.done, 0);
    check("rst match_count", bus.match_count, 0);
    check("rst any_match", bus.any_match, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    t4 = '0;
    t4[3] = 1'b1; t4[17] = 1'b1; t4[18] = 1'b1; t4[63] = 1'b1;

    run_scan('0, 0, 1'b0, "empty");
    run_scan(t4, 0, 1'b0, "four");
    run_scan(t4, 1, 1'b0, "four_toggle");
    run_scan({64{1'b1}}, 0, 1'b1, "all_ones");

    // Reset in the middle of a scan while an index is being offered
    bus.tags  = t4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.idx_ready = 1'b1;
    @(posedge clk); #1;
    bus.idx_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst pre_valid", bus.idx_valid, 1);
    check("midrst pre_idx", bus.idx, 17);
    check("midrst pre_count", bus.match_count, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst idx_valid", bus.idx_valid, 0);
    check("midrst match_count", bus.match_count, 0);
    check("midrst done", bus.done, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_scan(t4, 0, 1'b0, "after_rst");

    for (int n = 0; n < 4; n++) begin
      run_scan({$urandom, $urandom} & {$urandom, $urandom}, 2, 1'b0, "rand_sparse");
    end
    run_scan({$urandom, $urandom}, 2, 1'b0, "rand_dense");

`ifdef AP_SCAN_ABORT_EN
    t4 = '0;
    t4[5] = 1'b1; t4[40] = 1'b1;
    bus.tags  = t4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.idx_ready = 1'b1;
    check("abort idx5", bus.idx, 5);
    @(posedge clk); #1;
    abort = 1'b1;
    check("abort bubble_valid", bus.idx_valid, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort done", bus.done, 1);
    check("abort match_count", bus.match_count, 1);
    check("abort no40", bus.idx_valid, 0);
    @(posedge clk); #1;
    check("abort idle", bus.busy, 0);
    check("abort hold_count", bus.match_count, 1);
    bus.idx_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
